// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for register-register ALU instructions: fetch T0-T2, execute T3-T5(/T6).
// Optional MUL/DIV support (T5 loads LO, T6 loads HI) is enabled by defining MULDIV_EN.
module alu_instr_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned RSEL_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   ir,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                mdr_out,
    output logic                mar_in,
    output logic                pc_in,
    output logic                mdr_in,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                lo_in,
    output logic                hi_in,
    output logic                inc_pc,
    output logic                read,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [4:0]          alu_op,
    output logic                instr_done,
    output logic                illegal,
    output logic [15:0]         instr_count,
    output logic [3:0]          step
);

    localparam int unsigned RA_HI = DATA_W - OPC_W - 1;
    localparam int unsigned RB_HI = RA_HI - RSEL_W;
    localparam int unsigned RC_HI = RB_HI - RSEL_W;
    localparam int unsigned LO_HI = RC_HI - RSEL_W;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
`ifdef MULDIV_EN
        S_T6   = 4'd7,
`endif
        S_HALT = 4'd15
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    logic [OPC_W-1:0]  opc;
    logic [RSEL_W-1:0] ra, rb, rc;
    logic              op_legal;
    logic [4:0]        op_alu;
    logic              instr_ok;
    logic              unused_ir;
`ifdef MULDIV_EN
    logic              op_muldiv;
`endif

    assign opc       = ir[DATA_W-1 -: OPC_W];
    assign ra        = ir[RA_HI -: RSEL_W];
    assign rb        = ir[RB_HI -: RSEL_W];
    assign rc        = ir[RC_HI -: RSEL_W];
    assign unused_ir = ^ir[LO_HI:0];

    // Opcode decode: legality and the ALU select presented in T4
    always_comb begin
        op_legal = 1'b1;
        op_alu   = 5'(opc);
`ifdef MULDIV_EN
        op_muldiv = 1'b0;
`endif
        case (opc)
            OPC_W'(3), OPC_W'(4), OPC_W'(6), OPC_W'(7),
            OPC_W'(8), OPC_W'(9), OPC_W'(10): op_alu = 5'(opc);
            OPC_W'(5):  op_alu = 5'd15;
`ifdef MULDIV_EN
            OPC_W'(15): begin op_alu = 5'd16; op_muldiv = 1'b1; end
            OPC_W'(16): begin op_alu = 5'd17; op_muldiv = 1'b1; end
`endif
            default:    op_legal = 1'b0;
        endcase
    end

    assign instr_ok = op_legal && (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS)
                      && (32'(rc) < NUM_REGS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Step sequencing; the retire count advances on entry to each write-back step
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (instr_ok) begin
                    state_d = S_T4;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_T4: begin
                state_d = S_T5;
                count_d = count_q + 16'd1;
            end
            S_T5: begin
`ifdef MULDIV_EN
                if (op_muldiv) begin
                    state_d = S_T6;
                    count_d = count_q + 16'd1;
                end else
`endif
                state_d = run ? S_T0 : S_IDLE;
            end
`ifdef MULDIV_EN
            S_T6:   state_d = run ? S_T0 : S_IDLE;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobe decode; pc_in follows mem_ready so the PC loads once per fetch
    always_comb begin
        pc_out     = 1'b0;
        zlo_out    = 1'b0;
        mdr_out    = 1'b0;
        mar_in     = 1'b0;
        pc_in      = 1'b0;
        mdr_in     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        reg_in     = '0;
        reg_out    = '0;
        alu_op     = 5'd0;
        instr_done = 1'b0;
`ifdef MULDIV_EN
        zhi_out    = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;
`endif
        case (state_q)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlo_out = 1'b1;
                read    = 1'b1;
                mdr_in  = 1'b1;
                pc_in   = mem_ready;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (instr_ok) begin
                    reg_out = NUM_REGS'(1) << rb;
                    y_in    = 1'b1;
                end
            end
            S_T4: begin
                reg_out = NUM_REGS'(1) << rc;
                z_in    = 1'b1;
                alu_op  = op_alu;
            end
            S_T5: begin
                zlo_out    = 1'b1;
                instr_done = 1'b1;
`ifdef MULDIV_EN
                if (op_muldiv) lo_in = 1'b1;
                else           reg_in = NUM_REGS'(1) << ra;
`else
                reg_in = NUM_REGS'(1) << ra;
`endif
            end
`ifdef MULDIV_EN
            S_T6: begin
                zhi_out    = 1'b1;
                hi_in      = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifndef MULDIV_EN
    assign zhi_out = 1'b0;
    assign lo_in   = 1'b0;
    assign hi_in   = 1'b0;
`endif

    assign step        = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer: a per-instruction trace model queues expected
// strobe vectors; a negedge monitor pops and compares one vector per clock.
module tb_alu_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic        pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
    logic        y_in, z_in, lo_in, hi_in, inc_pc, read, instr_done, illegal;
    logic [15:0] reg_in, reg_out, instr_count;
    logic [4:0]  alu_op;
    logic [3:0]  step;

    alu_instr_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .lo_in(lo_in), .hi_in(hi_in),
        .inc_pc(inc_pc), .read(read), .reg_in(reg_in), .reg_out(reg_out),
        .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .instr_count(instr_count), .step(step)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  step;
        logic [15:0] cnt;
        logic        ill;
        logic        done;
        logic        pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
        logic        y_in, z_in, lo_in, hi_in, inc_pc, read;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [4:0]  alu_op;
    } vec_t;

    vec_t        act;
    vec_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] m_cnt;
    logic        m_ill;
    logic [31:0] cur_ir;

    assign act = {step, instr_count, illegal, instr_done, pc_out, zlo_out, zhi_out, mdr_out,
                  mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in, inc_pc, read,
                  reg_in, reg_out, alu_op};

    // Monitor: one expected vector per clock, compared mid-cycle
    initial begin
        vec_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL cycle_vec t=%0t step_exp=%0d actual=%h required=%h",
                             $time, e.step, act, e);
                end
            end
        end
    end

    function automatic vec_t base(input logic [3:0] s);
        vec_t v;
        v      = '0;
        v.step = s;
        v.cnt  = m_cnt;
        v.ill  = m_ill;
        return v;
    endfunction

    // {legal, muldiv, alu_op} from the opcode table
    function automatic logic [6:0] decode(input logic [4:0] opc);
        case (opc)
            5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return {2'b10, opc};
            5'd5:  return {2'b10, 5'd15};
`ifdef MULDIV_EN
            5'd15: return {2'b11, 5'd16};
            5'd16: return {2'b11, 5'd17};
`endif
            default: return 7'd0;
        endcase
    endfunction

    task automatic cyc(input vec_t e, input logic run_v, input logic mr_v);
        @(posedge clock);
        #1;
        run       = run_v;
        mem_ready = mr_v;
        ir        = cur_ir;
        exp_q.push_back(e);
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        m_cnt = 16'd0;
        m_ill = 1'b0;
        #1;
        checks++;
        if (act !== base(4'd0)) begin
            fails++;
            $display("FAIL async_reset actual=%h required=%h", act, base(4'd0));
        end
        cyc(base(4'd0), 1'b1, 1'($urandom));
        reset = 1'b0;
    endtask

    // Expected trace of one instruction; always leaves the sequencer heading into T0
    task automatic issue(input logic [31:0] ir_v, input int waits, input logic run_next,
                         input logic abort_t4);
        vec_t       e;
        logic [6:0] d;
        logic [3:0] ra, rb, rc;
        logic       mr;
        cur_ir = ir_v;
        d  = decode(ir_v[31:27]);
        ra = ir_v[26:23];
        rb = ir_v[22:19];
        rc = ir_v[18:15];
        e = base(4'd1); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
        cyc(e, 1'($urandom), 1'($urandom));
        for (int w = 0; w <= waits; w++) begin
            mr = (w == waits);
            e = base(4'd2); e.zlo_out = 1; e.read = 1; e.mdr_in = 1; e.pc_in = mr;
            cyc(e, 1'($urandom), mr);
        end
        e = base(4'd3); e.mdr_out = 1; e.ir_in = 1;
        cyc(e, 1'($urandom), 1'($urandom));
        if (!d[6] || ra >= 16 || rb >= 16 || rc >= 16) begin
            cyc(base(4'd4), 1'b1, 1'($urandom));
            m_ill = 1'b1;
            repeat (4) cyc(base(4'd15), 1'($urandom), 1'($urandom));
            async_reset();
            return;
        end
        e = base(4'd4); e.reg_out = 16'(1) << rb; e.y_in = 1;
        cyc(e, 1'($urandom), 1'($urandom));
        e = base(4'd5); e.reg_out = 16'(1) << rc; e.z_in = 1; e.alu_op = d[4:0];
        cyc(e, 1'($urandom), 1'($urandom));
        if (abort_t4) begin
            async_reset();
            return;
        end
        m_cnt = m_cnt + 16'd1;
        e = base(4'd6); e.zlo_out = 1; e.done = 1;
        if (d[5]) e.lo_in = 1;
        else      e.reg_in = 16'(1) << ra;
        cyc(e, d[5] ? 1'($urandom) : run_next, 1'($urandom));
        if (d[5]) begin
            m_cnt = m_cnt + 16'd1;
            e = base(4'd7); e.zhi_out = 1; e.hi_in = 1; e.done = 1;
            cyc(e, run_next, 1'($urandom));
        end
        if (!run_next) begin
            repeat ($urandom_range(0, 2)) cyc(base(4'd0), 1'b0, 1'($urandom));
            cyc(base(4'd0), 1'b1, 1'($urandom));
        end
    endtask

    initial begin
        logic [31:0] r_ir;
        logic [4:0]  opc;
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        ir        = 32'd0;
        cur_ir    = 32'd0;
        m_cnt     = 16'd0;
        m_ill     = 1'b0;
        cyc(base(4'd0), 1'b1, 1'b1);
        cyc(base(4'd0), 1'b1, 1'b1);
        reset = 1'b0;

        issue(32'h28918000, 0, 1'b1, 1'b0);
        issue(32'h18918000, 3, 1'b1, 1'b0);
        issue(32'h18918000, 0, 1'b1, 1'b0);
        issue(32'h18918000, 1, 1'b0, 1'b0);
        issue(32'hF8000000, 0, 1'b1, 1'b0);
        issue(32'h20918000, 0, 1'b1, 1'b1);
        issue(32'h78918000, 2, 1'b0, 1'b0);
        issue(32'h80918000, 0, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 7) opc = 5'($urandom_range(3, 10));
            else                          opc = 5'($urandom);
            r_ir = {opc, 27'($urandom)};
            issue(r_ir, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 11) == 0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Parametrised control-step sequencer that generates every datapath control strobe for register–register ALU instructions.
- Runs the fetch (T0–T2) and execute (T3–T5) steps currently hand-sequenced in simulation, for a full opcode set, a configurable register file and a memory-ready handshake.
- Sits beside DataPath: it consumes the IR contents and drives the datapath's out/in enables and ALU control.

Parameters:
- DATA_W, 32, width of the IR input.
- NUM_REGS, 16, number of general registers; sets the width of the one-hot reg_in/reg_out buses.
- OPC_W, 5, opcode field width, IR[DATA_W-1 -: OPC_W].
- RSEL_W, 4, register field width; ra = IR[26:23], rb = IR[22:19], rc = IR[18:15] at the defaults.

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- run, in, 1, level-sensitive; enables instruction issue.
- mem_ready, in, 1, memory has valid read data this cycle.
- ir, in, DATA_W, current IR register contents from the datapath.
- pc_out, zlo_out, zhi_out, mdr_out, out, 1 each, bus-drive enables.
- mar_in, pc_in, mdr_in, ir_in, y_in, z_in, lo_in, hi_in, out, 1 each, register load enables.
- inc_pc, read, out, 1 each, PC-increment select and memory read request.
- reg_in, out, NUM_REGS, one-hot general-register load enables.
- reg_out, out, NUM_REGS, one-hot general-register drive enables.
- alu_op, out, 5, ALU operation select.
- instr_done, out, 1, one-cycle pulse on the final execute step.
- illegal, out, 1, sticky flag: unsupported opcode or out-of-range register field.
- instr_count, out, 16, count of retired instructions.
- step, out, 4, encoded current state, for debug.

Behaviour:
- Reset (async, active-high): state = IDLE; every output = 0; instr_count = 0; illegal = 0. Reset mid-instruction abandons it immediately.
- Control outputs are a Moore decode of the state register plus the ir fields. At most one bus-drive enable is high in any state.
- States and required outputs:
  - IDLE (0): no outputs. run=1 → T0.
  - T0 (1): pc_out, mar_in, inc_pc, z_in. → T1.
  - T1 (2): zlo_out, pc_in, read, mdr_in.
    - Held while mem_ready=0; read and mdr_in stay high throughout.
    - pc_in is high only in the cycle where mem_ready=1, so PC loads exactly once. → T2 on mem_ready=1.
  - T2 (3): mdr_out, ir_in. → T3.
  - T3 (4): ir is now valid. Decode opcode; check ra/rb/rc < NUM_REGS.
    - If legal: reg_out[rb], y_in. → T4.
    - If illegal: no outputs; illegal ← 1. → HALT.
  - T4 (5): reg_out[rc], z_in, alu_op = decoded op. → T5.
  - T5 (6): zlo_out, reg_in[ra], instr_done; instr_count++ (wraps 0xFFFF → 0).
    - → T0 if run=1, else IDLE.
    - For MULDIV ops, T5 asserts lo_in instead of reg_in[ra] and → T6.
  - T6 (7): MULDIV only. zhi_out, hi_in, instr_done, instr_count++. Then the same run check as T5.
  - HALT (15): no outputs. Exits only on reset.
- Opcode map (alu_op = opcode unless noted):
  - 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol.
  - 00101 (and) drives alu_op = 01111.
  - All other opcodes are illegal.
- alu_op is 0 outside T4.
- run deasserted mid-instruction: the instruction completes, then the sequencer returns to IDLE.
- ra = rb = rc is legal; no special handling.
- Writes to R0 are permitted.

Optional Feature:
- Macro MULDIV_EN.
- Defined: opcodes 01111 (mul, alu_op 10000) and 10000 (div, alu_op 10001) are legal. They use the T5(lo_in)/T6(hi_in) path; zhi_out, lo_in and hi_in are live.
- Undefined: both opcodes are illegal; state T6 does not exist; zhi_out, lo_in and hi_in are tied to 0.

Test Plan:
- Reset with run=1, mem_ready=1, ir=0x28918000 → IDLE, then T0..T5 in 6 cycles.
  - T3: reg_out=0x0004, y_in=1. T4: reg_out=0x0008, alu_op=01111. T5: reg_in=0x0002, instr_done=1, instr_count=1.
- Hold mem_ready=0 for 3 cycles in T1 → read and mdr_in high for 4 cycles; pc_in high only in the last of them; T2 follows.
- Keep run=1 for 3 back-to-back add instructions (ir=0x18918000) → no IDLE between them; instr_count=3. Drop run during the third instruction's T4 → IDLE after T5.
- ir opcode 11111 → illegal=1 at the end of T3; state HALT; all strobes 0 until reset. With NUM_REGS=8, ra=9 gives the same result.
- Assert reset during T4 → all outputs 0 asynchronously; instr_count=0; IDLE.
- MULDIV_EN, ir opcode 01111 → T5: zlo_out and lo_in high. T6: zhi_out and hi_in high; a single instr_done per cycle; instr_count increments by 2 over T5–T6.
